// File: rtl/ad9643_pkg.sv
// Shared register map, reset defaults and SPI FSM states for the AD9643 register model.
package ad9643_pkg;

  localparam logic [12:0] ADDR_SPI_CFG    = 13'h0000;
  localparam logic [12:0] ADDR_CHIP_ID    = 13'h0001;
  localparam logic [12:0] ADDR_CHIP_GRADE = 13'h0002;
  localparam logic [12:0] ADDR_CHAN_IDX   = 13'h0005;
  localparam logic [12:0] ADDR_POWER      = 13'h0008;
  localparam logic [12:0] ADDR_TEST       = 13'h000D;
  localparam logic [12:0] ADDR_OUTPUT     = 13'h0014;
  localparam logic [12:0] ADDR_XFER       = 13'h00FF;

  localparam logic [7:0] DEF_SPI_CFG  = 8'h18;
  localparam logic [7:0] DEF_CHAN_IDX = 8'h03;
  localparam logic [7:0] DEF_POWER    = 8'h00;
  localparam logic [7:0] DEF_TEST     = 8'h00;
  localparam logic [7:0] DEF_OUTPUT   = 8'h00;
  localparam logic [7:0] DEF_XFER     = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/ad9643_spi_regs_sync_edge.sv
// Two-flop synchroniser with rise/fall detection of the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser stages plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/ad9643_spi_regs.sv
// ADI 3-wire SPI slave and shadow/active configuration registers for the AD9643 model.
module ad9643_spi_regs
  import ad9643_pkg::*;
#(
  parameter logic [7:0] CHIP_ID    = 8'h82,
  parameter logic [7:0] CHIP_GRADE = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss_n,
  inout  wire        sdio,
  output logic [1:0] power_mode,
  output logic [3:0] test_mode,
  output logic [7:0] output_mode,
  output logic [1:0] chan_index
);

  logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
  logic ss_sync_s, ss_fall_s, ss_rise_unused_s;
  logic sdio_meta_r, sdio_sync_r;

  spi_state_t  state_r, state_nxt_s;
  logic [14:0] shift_r;
  logic [3:0]  bit_cnt_r;
  logic        rw_r;
  logic [1:0]  w_r, bytes_r;
  logic [12:0] addr_r;
  logic [7:0]  rd_shift_r;
  logic        sdio_oe_r, sdio_out_r;

  logic [7:0]  cfg_r, chan_r, pwr_sh_r, test_sh_r, out_sh_r;
  logic [1:0]  pwr_act_r;
  logic [3:0]  test_act_r;
  logic [7:0]  out_act_r;
  logic        xfer_r;

  logic [15:0] instr_s;
  logic        instr_done_s, byte_done_s, last_byte_s;
  logic [12:0] next_addr_s, rd_addr_s;
  logic [7:0]  rd_data_s, wr_data_s;
  logic        wr_en_s, soft_rst_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(ss_n),
    .level(ss_sync_s), .rise(ss_rise_unused_s), .fall(ss_fall_s)
  );

  // sdio input synchroniser, same latency as the sclk edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdio_meta_r <= 1'b0;
      sdio_sync_r <= 1'b0;
    end else begin
      sdio_meta_r <= sdio;
      sdio_sync_r <= sdio_meta_r;
    end
  end

  assign instr_s      = {shift_r, sdio_sync_r};
  assign instr_done_s = sclk_rise_s & ~ss_sync_s & (state_r == INSTR) & (bit_cnt_r == 4'd15);
  assign byte_done_s  = sclk_rise_s & ~ss_sync_s & (state_r == DATA) & (bit_cnt_r == 4'd7);
  assign last_byte_s  = (w_r != 2'b11) & (bytes_r == 2'b00);
  assign next_addr_s  = addr_r - 13'd1;
  assign wr_data_s    = {shift_r[6:0], sdio_sync_r};
  assign wr_en_s      = byte_done_s & ~rw_r;
  assign soft_rst_s   = wr_en_s & (addr_r == ADDR_SPI_CFG) & (wr_data_s[5] | wr_data_s[2]);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next state; ss_n high aborts from any state
  always_comb begin
    state_nxt_s = state_r;
    if (ss_sync_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (ss_fall_s)                   state_nxt_s = INSTR; else state_nxt_s = IDLE;
        INSTR:   if (instr_done_s)                state_nxt_s = DATA;  else state_nxt_s = INSTR;
        DATA:    if (byte_done_s && last_byte_s)  state_nxt_s = DONE;  else state_nxt_s = DATA;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // read mux: the address of the byte about to start
  always_comb begin
    rd_addr_s = (state_r == INSTR) ? instr_s[12:0] : next_addr_s;
    case (rd_addr_s)
      ADDR_SPI_CFG:    rd_data_s = cfg_r;
      ADDR_CHIP_ID:    rd_data_s = CHIP_ID;
      ADDR_CHIP_GRADE: rd_data_s = CHIP_GRADE;
      ADDR_CHAN_IDX:   rd_data_s = chan_r;
      ADDR_POWER:      rd_data_s = pwr_sh_r;
      ADDR_TEST:       rd_data_s = test_sh_r;
      ADDR_OUTPUT:     rd_data_s = out_sh_r;
      ADDR_XFER:       rd_data_s = DEF_XFER;
      default:         rd_data_s = 8'h00;
    endcase
  end

  // serial shifter, byte/address bookkeeping and sdio driver
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= 15'd0;
      bit_cnt_r  <= 4'd0;
      rw_r       <= 1'b0;
      w_r        <= 2'b00;
      bytes_r    <= 2'b00;
      addr_r     <= 13'd0;
      rd_shift_r <= 8'h00;
      sdio_oe_r  <= 1'b0;
      sdio_out_r <= 1'b0;
    end else if (ss_sync_s) begin
      bit_cnt_r <= 4'd0;
      sdio_oe_r <= 1'b0;
    end else if (sclk_rise_s) begin
      case (state_r)
        INSTR: begin
          shift_r   <= instr_s[14:0];
          bit_cnt_r <= bit_cnt_r + 4'd1;
          if (instr_done_s) begin
            rw_r       <= instr_s[15];
            w_r        <= instr_s[14:13];
            bytes_r    <= instr_s[14:13];
            addr_r     <= instr_s[12:0];
            bit_cnt_r  <= 4'd0;
            rd_shift_r <= rd_data_s;
          end
        end
        DATA: begin
          shift_r   <= {shift_r[13:0], sdio_sync_r};
          bit_cnt_r <= bit_cnt_r + 4'd1;
          if (byte_done_s) begin
            bit_cnt_r  <= 4'd0;
            addr_r     <= next_addr_s;
            bytes_r    <= bytes_r - 2'd1;
            rd_shift_r <= rd_data_s;
          end
        end
        default: begin
        end
      endcase
    end else if (sclk_fall_s && (state_r == DATA) && rw_r) begin
      sdio_oe_r  <= 1'b1;
      sdio_out_r <= rd_shift_r[7];
      rd_shift_r <= {rd_shift_r[6:0], 1'b0};
    end
  end

  // register file: SPI commits, soft reset and shadow-to-active transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst || soft_rst_s) begin
      cfg_r      <= DEF_SPI_CFG;
      chan_r     <= DEF_CHAN_IDX;
      pwr_sh_r   <= DEF_POWER;
      test_sh_r  <= DEF_TEST;
      out_sh_r   <= DEF_OUTPUT;
      pwr_act_r  <= DEF_POWER[1:0];
      test_act_r <= DEF_TEST[3:0];
      out_act_r  <= DEF_OUTPUT;
      xfer_r     <= 1'b0;
    end else begin
      xfer_r <= 1'b0;
      if (xfer_r) begin
        pwr_act_r  <= pwr_sh_r[1:0];
        test_act_r <= test_sh_r[3:0];
        out_act_r  <= out_sh_r;
      end
      if (wr_en_s) begin
        case (addr_r)
          ADDR_SPI_CFG:  cfg_r     <= wr_data_s;
          ADDR_CHAN_IDX: chan_r    <= wr_data_s;
          ADDR_POWER:    pwr_sh_r  <= wr_data_s;
          ADDR_TEST:     test_sh_r <= wr_data_s;
          ADDR_OUTPUT:   out_sh_r  <= wr_data_s;
          ADDR_XFER:     xfer_r    <= wr_data_s[0];
          default: begin
          end
        endcase
      end
    end
  end

  assign sdio        = sdio_oe_r ? sdio_out_r : 1'bz;
  assign power_mode  = pwr_act_r;
  assign test_mode   = test_act_r;
  assign output_mode = out_act_r;
  assign chan_index  = chan_r[1:0];

endmodule

// File: tb/tb_ad9643_spi_regs.sv
// Directed bench for ad9643_spi_regs: SPI reads/writes, transfer, soft reset, aborts.
module tb_ad9643_spi_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       tb_oe = 1'b0;
  logic       tb_do = 1'b0;
  wire        sdio_w;
  logic [1:0] power_mode;
  logic [3:0] test_mode;
  logic [7:0] output_mode;
  logic [1:0] chan_index;

  logic [7:0] wbuf [0:2];
  logic [7:0] rbuf [0:2];
  int n_checks = 0;
  int n_pass   = 0;

  assign sdio_w = tb_oe ? tb_do : 1'bz;
  pullup (sdio_w);

  ad9643_spi_regs dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .sdio(sdio_w),
    .power_mode(power_mode), .test_mode(test_mode),
    .output_mode(output_mode), .chan_index(chan_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // one sclk period: falling edge, low phase (sample read data late), rising edge
  task automatic spi_bit(input logic b, output logic r);
    sclk  = 1'b0;
    tb_do = b;
    #45;
    r = sdio_w;
    #5;
    sclk = 1'b1;
    #50;
  endtask

  task automatic spi_txn(input logic rw, input logic [1:0] w, input logic [12:0] addr, input int nbits);
    logic [15:0] instr;
    logic        r;
    instr = {rw, w, addr};
    ss_n  = 1'b0;
    #100;
    tb_oe = 1'b1;
    for (int i = 15; i >= 0; i--) spi_bit(instr[i], r);
    #40;
    if (rw) begin
      tb_oe = 1'b0;
      #5;
      check_eq("sdio_z_pre_data", sdio_w, 1'b1);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_bit(wbuf[i / 8][7 - (i % 8)], r);
      rbuf[i / 8][7 - (i % 8)] = r;
    end
    sclk = 1'b0;
    #100;
    ss_n = 1'b1;
    #100;
    tb_oe = 1'b0;
  endtask

  task automatic wr1(input logic [12:0] addr, input logic [7:0] d);
    wbuf[0] = d;
    spi_txn(1'b0, 2'b00, addr, 8);
  endtask

  task automatic rd1(input logic [12:0] addr, output logic [7:0] d);
    wbuf[0] = 8'h00;
    spi_txn(1'b1, 2'b00, addr, 8);
    d = rbuf[0];
  endtask

  initial begin
    logic [7:0] d;
    logic       r;
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = 8'h00;
      rbuf[i] = 8'h00;
    end
    #42;
    rst = 1'b0;
    #20;
    check_eq("rst_power_mode", power_mode, 2'b00);
    check_eq("rst_test_mode", test_mode, 4'h0);
    check_eq("rst_output_mode", output_mode, 8'h00);
    check_eq("rst_chan_index", chan_index, 2'b11);
    check_eq("rst_sdio_z", sdio_w, 1'b1);

    rd1(13'h0001, d);  check_eq("rd_chip_id", d, 8'h82);
    check_eq("sdio_z_after_ss", sdio_w, 1'b1);
    rd1(13'h0000, d);  check_eq("rd_spi_cfg", d, 8'h18);

    wr1(13'h000D, 8'h05);
    check_eq("test_mode_before_xfer", test_mode, 4'h0);
    rd1(13'h000D, d);  check_eq("rd_test_shadow", d, 8'h05);
    wr1(13'h00FF, 8'h01);
    check_eq("test_mode_after_xfer", test_mode, 4'h5);
    rd1(13'h00FF, d);  check_eq("rd_xfer_zero", d, 8'h00);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    spi_txn(1'b0, 2'b01, 13'h0014, 16);
    rd1(13'h0014, d);  check_eq("rd_output_shadow", d, 8'hA5);
    rd1(13'h0013, d);  check_eq("rd_unmapped_13", d, 8'h00);
    check_eq("output_mode_no_xfer", output_mode, 8'h00);

    wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h00;
    spi_txn(1'b1, 2'b11, 13'h0005, 24);
    check_eq("stream_b0", rbuf[0], 8'h03);
    check_eq("stream_b1", rbuf[1], 8'h00);
    check_eq("stream_b2", rbuf[2], 8'h00);

    spi_txn(1'b1, 2'b10, 13'h0001, 24);
    check_eq("wrap_b0", rbuf[0], 8'h82);
    check_eq("wrap_b1", rbuf[1], 8'h18);
    check_eq("wrap_b2_1fff", rbuf[2], 8'h00);

    wbuf[0] = 8'h00;
    spi_txn(1'b0, 2'b00, 13'h0005, 4);
    rd1(13'h0005, d);  check_eq("rd_chan_after_abort", d, 8'h03);
    check_eq("chan_after_abort", chan_index, 2'b11);
    wr1(13'h0005, 8'h01);
    check_eq("chan_after_write", chan_index, 2'b01);

    wr1(13'h0008, 8'h02);
    check_eq("power_before_xfer", power_mode, 2'b00);
    wr1(13'h00FF, 8'h01);
    check_eq("power_after_xfer", power_mode, 2'b10);
    check_eq("output_after_xfer", output_mode, 8'hA5);

    wr1(13'h0000, 8'h3C);
    rd1(13'h0000, d);  check_eq("rd_cfg_after_srst", d, 8'h18);
    rd1(13'h000D, d);  check_eq("rd_test_after_srst", d, 8'h00);
    rd1(13'h0014, d);  check_eq("rd_output_after_srst", d, 8'h00);
    check_eq("chan_after_srst", chan_index, 2'b11);
    check_eq("test_mode_after_srst", test_mode, 4'h0);
    check_eq("power_after_srst", power_mode, 2'b00);
    check_eq("output_after_srst", output_mode, 8'h00);

    // reset while the DUT drives bit7 (0) of 0x18
    ss_n = 1'b0;
    #100;
    tb_oe = 1'b1;
    for (int i = 15; i >= 0; i--) spi_bit((i == 15) ? 1'b1 : 1'b0, r);
    #40;
    tb_oe = 1'b0;
    spi_bit(1'b0, r);
    check_eq("mid_read_bit7", r, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("sdio_z_on_rst", sdio_w, 1'b1);
    ss_n = 1'b1;
    sclk = 1'b0;
    #50;
    rst = 1'b0;
    #100;
    check_eq("chan_after_rst", chan_index, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
